// File: rtl/alien_formation_if.sv
// Signal bundle between the formation controller and the rest of the game:
// collision/player inputs in, formation position and status out.
interface alien_formation_if;
    logic        Game_Enable;
    logic [49:0] Aliens_Grid;
    logic [8:0]  Player_Row;
    logic [8:0]  Aliens_Row;
    logic [9:0]  Aliens_Col;
    logic        Aliens_Dir;
    logic        Step_Pulse;
    logic        Invaded;

    modport master (
        output Game_Enable, Aliens_Grid, Player_Row,
        input  Aliens_Row, Aliens_Col, Aliens_Dir, Step_Pulse, Invaded
    );

    modport slave (
        input  Game_Enable, Aliens_Grid, Player_Row,
        output Aliens_Row, Aliens_Col, Aliens_Dir, Step_Pulse, Invaded
    );
endinterface

// File: rtl/alien_formation.sv
// Space-invaders formation mover: steps the 10x5 alien block sideways, drops
// at the screen edges, speeds up as aliens die and halts on invasion.
//
//   state  | meaning
//   MOVE_R | stepping right, drop and turn at right edge
//   MOVE_L | stepping left, drop and turn at left edge
//   HALT   | formation reached the player; frozen until Reset
module alien_formation #(
    parameter int BasePeriod  = 2000000,
    parameter int StartRow    = 40,
    parameter int StartCol    = 120,
    parameter int StepX       = 10,
    parameter int StepY       = 10,
    parameter int ScreenWidth = 640
) (
    input  logic              Clk,
    input  logic              Reset,
    alien_formation_if.slave  bus
);

    typedef enum logic [1:0] {MOVE_R, MOVE_L, HALT} state_t;

    function automatic logic [23:0] clamp_period(input int p);
        return (p < 1) ? 24'd1 : 24'(p);
    endfunction

    localparam logic [23:0] P_FULL   = clamp_period(BasePeriod);
    localparam logic [23:0] P_HALF   = clamp_period(BasePeriod / 2);
    localparam logic [23:0] P_QTR    = clamp_period(BasePeriod / 4);
    localparam logic [23:0] P_EIGHTH = clamp_period(BasePeriod / 8);

    state_t      state;
    logic [23:0] cnt;

    logic [5:0]  n_live;
    logic [9:0]  col_live;
    logic [4:0]  row_live;
    logic [3:0]  left_col;
    logic [3:0]  right_col;
    logic [2:0]  bottom_row;
    logic [23:0] period;
    logic [11:0] right_px;
    logic [11:0] left_px;
    logic [11:0] bottom_px;
    logic        hit_right;
    logic        hit_left;
    logic        invade;
    logic        active;
    logic        tick;

    always_comb begin
        n_live     = '0;
        col_live   = '0;
        row_live   = '0;
        left_col   = '0;
        right_col  = '0;
        bottom_row = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 10; c++) begin
                n_live = n_live + 6'(bus.Aliens_Grid[r*10+c]);
                if (bus.Aliens_Grid[r*10+c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
        // Descending scan leaves the smallest live column; ascending the largest.
        for (int c = 9; c >= 0; c--)
            if (col_live[c]) left_col = 4'(c);
        for (int c = 0; c < 10; c++)
            if (col_live[c]) right_col = 4'(c);
        for (int r = 0; r < 5; r++)
            if (row_live[r]) bottom_row = 3'(r);
    end

    always_comb begin
        if (n_live > 6'd25)      period = P_FULL;
        else if (n_live > 6'd10) period = P_HALF;
        else if (n_live > 6'd3)  period = P_QTR;
        else                     period = P_EIGHTH;
    end

    assign right_px  = 12'(bus.Aliens_Col) + 12'(right_col) * 12'd40 + 12'd30 + 12'(StepX);
    assign left_px   = 12'(bus.Aliens_Col) + 12'(left_col) * 12'd40;
    assign bottom_px = 12'(bus.Aliens_Row) + 12'(bottom_row) * 12'd30 + 12'd20;
    assign hit_right = right_px > 12'(ScreenWidth);
    assign hit_left  = left_px < 12'(StepX);
    assign invade    = (n_live != 6'd0) && (bottom_px >= 12'(bus.Player_Row));
    assign active    = (state != HALT) && bus.Game_Enable && (n_live != 6'd0);
    assign tick      = active && (cnt >= period - 24'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= MOVE_R;
            cnt            <= '0;
            bus.Aliens_Row <= 9'(StartRow);
            bus.Aliens_Col <= 10'(StartCol);
            bus.Aliens_Dir <= 1'b0;
            bus.Step_Pulse <= 1'b0;
            bus.Invaded    <= 1'b0;
        end else begin
            bus.Step_Pulse <= 1'b0;
            if (state != HALT) begin
                if (invade) begin
                    // Invasion wins over any tick landing in the same cycle.
                    state          <= HALT;
                    bus.Invaded    <= 1'b1;
                    bus.Aliens_Dir <= 1'b0;
                end else if (tick) begin
                    cnt            <= '0;
                    bus.Step_Pulse <= 1'b1;
                    if (state == MOVE_R) begin
                        if (hit_right) begin
                            bus.Aliens_Row <= bus.Aliens_Row + 9'(StepY);
                            state          <= MOVE_L;
                            bus.Aliens_Dir <= 1'b1;
                        end else begin
                            bus.Aliens_Col <= bus.Aliens_Col + 10'(StepX);
                        end
                    end else begin
                        if (hit_left) begin
                            bus.Aliens_Row <= bus.Aliens_Row + 9'(StepY);
                            state          <= MOVE_R;
                            bus.Aliens_Dir <= 1'b0;
                        end else begin
                            bus.Aliens_Col <= bus.Aliens_Col - 10'(StepX);
                        end
                    end
                end else if (active) begin
                    cnt <= cnt + 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alien_formation.sv
// Directed bench for alien_formation with BasePeriod=4: stepping, edge drops,
// period scaling, pause, empty grid, invasion halt and reset recovery.
module tb_alien_formation;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    alien_formation_if bus();

    alien_formation #(.BasePeriod(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advances at least one cycle; returns cycles until Step_Pulse seen (or max).
    task automatic wait_pulse(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge Clk);
            cyc++;
        end while (bus.Step_Pulse !== 1'b1 && cyc < max);
        if (bus.Step_Pulse !== 1'b1) chk("pulse_timeout", 0, 1);
    endtask

    task automatic do_reset(input logic [49:0] grid, input int prow);
        Reset = 1'b1;
        bus.Game_Enable = 1'b1;
        bus.Aliens_Grid = grid;
        bus.Player_Row  = 9'(prow);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        bus.Game_Enable = 1'b1;
        bus.Aliens_Grid = '1;
        bus.Player_Row  = 9'd440;
        repeat (3) @(negedge Clk);
        chk("rst_row", int'(bus.Aliens_Row), 40);
        chk("rst_col", int'(bus.Aliens_Col), 120);
        chk("rst_dir", int'(bus.Aliens_Dir), 0);
        chk("rst_pulse", int'(bus.Step_Pulse), 0);
        chk("rst_inv", int'(bus.Invaded), 0);
        Reset = 1'b0;

        // Full grid sweeping right: period 4, col 130..250
        for (int k = 1; k <= 13; k++) begin
            wait_pulse(20, n);
            chk("right_period", n, 4);
            chk("right_col", int'(bus.Aliens_Col), 120 + 10 * k);
        end
        wait_pulse(20, n);
        chk("rdrop_row", int'(bus.Aliens_Row), 50);
        chk("rdrop_col", int'(bus.Aliens_Col), 250);
        chk("rdrop_dir", int'(bus.Aliens_Dir), 1);

        for (int k = 1; k <= 25; k++) begin
            wait_pulse(20, n);
            chk("left_period", n, 4);
            chk("left_col", int'(bus.Aliens_Col), 250 - 10 * k);
        end
        wait_pulse(20, n);
        chk("ldrop_row", int'(bus.Aliens_Row), 60);
        chk("ldrop_col", int'(bus.Aliens_Col), 0);
        chk("ldrop_dir", int'(bus.Aliens_Dir), 0);

        // Pause with counter at 1; three more cycles to the next tick afterwards
        @(negedge Clk);
        bus.Game_Enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("pause_pulse", int'(bus.Step_Pulse), 0);
        end
        chk("pause_col", int'(bus.Aliens_Col), 0);
        bus.Game_Enable = 1'b1;
        wait_pulse(20, n);
        chk("resume_period", n, 3);
        chk("resume_col", int'(bus.Aliens_Col), 10);

        // N=25 gives half period; switching to N=26 restores the full period
        do_reset(50'h1FFFFFF, 440);
        wait_pulse(20, n);
        chk("n25_period_a", n, 2);
        chk("n25_col", int'(bus.Aliens_Col), 130);
        wait_pulse(20, n);
        chk("n25_period_b", n, 2);
        bus.Aliens_Grid = 50'h3FFFFFF;
        wait_pulse(20, n);
        chk("n26_period", n, 4);
        chk("n26_col", int'(bus.Aliens_Col), 150);

        // Single alien: tick every cycle, right drop once col exceeds 600
        do_reset(50'h1, 440);
        for (int k = 1; k <= 49; k++) begin
            wait_pulse(10, n);
            chk("single_period", n, 1);
            chk("single_col", int'(bus.Aliens_Col), 120 + 10 * k);
        end
        wait_pulse(10, n);
        chk("single_drop_row", int'(bus.Aliens_Row), 50);
        chk("single_drop_col", int'(bus.Aliens_Col), 610);
        chk("single_drop_dir", int'(bus.Aliens_Dir), 1);

        // Empty grid: frozen but not halted
        bus.Aliens_Grid = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            chk("empty_pulse", int'(bus.Step_Pulse), 0);
            chk("empty_inv", int'(bus.Invaded), 0);
        end
        chk("empty_col", int'(bus.Aliens_Col), 610);
        chk("empty_dir", int'(bus.Aliens_Dir), 1);
        bus.Aliens_Grid = 50'h1;
        wait_pulse(10, n);
        chk("refill_period", n, 1);
        chk("refill_col", int'(bus.Aliens_Col), 600);

        // Invasion: first drop puts bottom edge at 50+140=190
        do_reset('1, 190);
        for (int k = 1; k <= 13; k++) wait_pulse(20, n);
        chk("inv_pre_col", int'(bus.Aliens_Col), 250);
        chk("inv_pre_flag", int'(bus.Invaded), 0);
        wait_pulse(20, n);
        chk("inv_drop_row", int'(bus.Aliens_Row), 50);
        chk("inv_drop_flag", int'(bus.Invaded), 0);
        @(negedge Clk);
        chk("inv_flag", int'(bus.Invaded), 1);
        chk("inv_dir", int'(bus.Aliens_Dir), 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            chk("halt_pulse", int'(bus.Step_Pulse), 0);
        end
        chk("halt_row", int'(bus.Aliens_Row), 50);
        chk("halt_col", int'(bus.Aliens_Col), 250);
        chk("halt_inv", int'(bus.Invaded), 1);

        // Reset out of HALT
        Reset = 1'b1;
        bus.Player_Row = 9'd440;
        @(negedge Clk);
        chk("hrst_row", int'(bus.Aliens_Row), 40);
        chk("hrst_col", int'(bus.Aliens_Col), 120);
        chk("hrst_inv", int'(bus.Invaded), 0);
        chk("hrst_dir", int'(bus.Aliens_Dir), 0);
        Reset = 1'b0;
        wait_pulse(20, n);
        chk("hrst_period", n, 4);
        chk("hrst_move_col", int'(bus.Aliens_Col), 130);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
